idct_da_module: RTL and testbench
=================================

Name: idct_da_module

Overview:
- Distributed-arithmetic 8-point inverse DCT core, the decode-side counterpart of the DA DCT core.
- Accepts one set of 8 quantised DCT coefficients through a valid/ready handshake.
- Serialises the coefficients bit by bit (LSB first) and forms offset-binary ROM addresses for two 4-input partial-product ROMs.
- Shift-accumulates the ROM terms and returns one reconstructed EEG sample through a valid/ready handshake. One instance is used per output sample index; each has its own ROM pair, which sits outside the block.

Parameters:
- IN_W, 8: coefficient width in bits, two's complement. Also the number of serial cycles per pass.
- ROM_W, 16: width of a ROM word, signed.
- OUT_W, 19: accumulator and output width. Must be at least ROM_W+3.

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  coefficient set valid
- in_ready  out  1  core can accept a coefficient set
- coef0..coef7  in  IN_W each  signed DCT coefficients; sampled only on the input handshake
- addr1  out  3  ROM1 address, taken from coefficients 0-3
- addr2  out  3  ROM2 address, taken from coefficients 4-7
- rom1_data  in  ROM_W  ROM1 word; asynchronous read, valid in the same cycle as addr1
- rom2_data  in  ROM_W  ROM2 word; asynchronous read, valid in the same cycle as addr2
- out_valid  out  1  reconstructed sample valid
- out_ready  in  1  downstream accepts the sample
- out_data  out  OUT_W  reconstructed sample, signed
- busy  out  1  high while in SHIFT

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is synchronous and active-low.
  - On reset: state IDLE, shift registers 0, accumulator 0, bit counter 0.
  - Outputs on reset: out_data=0, out_valid=0, in_ready=1 (combinational from IDLE), busy=0, addr1=addr2=0.
  - Reset asserted mid-pass aborts the pass. No output is produced for the aborted set.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. On in_valid: load coef0..7 into the 8 shift registers, clear the accumulator, set bit counter j=0, go to SHIFT.
  - SHIFT: runs exactly IN_W cycles. Each cycle processes bit j (the shift-register LSB), then shifts each register right by 1 and increments j. After j=IN_W-1, go to DONE.
  - DONE: out_valid=1, and out_data holds the final accumulator until the output handshake (out_valid & out_ready).
    - On handshake with in_valid=0: go to IDLE.
    - In DONE, in_ready = out_ready. Handshake together with in_valid: load the new set and go straight to SHIFT. This gives back-to-back passes with no bubble.
- Latency: input handshake in cycle t; SHIFT occupies cycles t+1..t+IN_W; out_valid is first high in cycle t+IN_W+1. Peak throughput is one sample per IN_W+1 cycles.
- Per-cycle datapath in SHIFT, with b_k = LSB of coefficient k's shift register:
  - addr1 = {b0^b1, b0^b2, b0^b3}; sel1 = b0.
  - addr2 = {b4^b5, b4^b6, b4^b7}; sel2 = b4.
  - P1 = sel1 ? −rom1_data : rom1_data; P2 = sel2 ? −rom2_data : rom2_data. Both are computed at ROM_W+2 bits and sign-extended.
  - T = P1 + P2, ROM_W+2 bits. No overflow is possible at this width.
  - For j<IN_W-1: acc ← (acc >>> 1) + sext(T). For j=IN_W-1 (sign bit): acc ← (acc >>> 1) − sext(T).
  - The shift is arithmetic and truncates toward −∞. The accumulator is OUT_W bits and wraps modulo 2^OUT_W. No saturation.
- ROM address outputs: addr1/addr2 are 0 outside SHIFT. rom data is ignored outside SHIFT.
- Input stability: coefficients changing after the load handshake have no effect.
- Input handshake while out_valid is high and out_ready=0: not possible, because in_ready=0 in that case.

Decomposition:
- Shared package idct_pkg holds:
  - the state enum {IDLE, SHIFT, DONE};
  - the default widths IN_W/ROM_W/OUT_W;
  - the constant CNT_W = $clog2(IN_W).
- One sub-module, coef_shift_reg #(IN_W): parallel-load, right-shift register with load, shift and sync-reset controls, exposing its LSB. It is instantiated 8 times.
- The sign select, adder, accumulator and FSM stay in the top module.

Test Plan (IN_W=8):
- All coefs 0, ROM1[0]=100, ROM2[0]=28.
  - Required: T=128 on every cycle; acc sequence 128, 192, 224, 240, 248, 252, 254, then −1.
  - Required: out_data=−1 (0x7FFFF), out_valid high in cycle t+9.
- coef0=−1 and coef1..7=0, ROM1[7]=64, ROM2[0]=28.
  - Required: addr1=7 and addr2=0 on all 8 cycles; T=−36.
  - Required: acc sequence −36, −54, −63, −68, −70, −71, −72, then 0; out_data=0.
- Hold out_ready=0 for 5 cycles after DONE.
  - Required: out_data stable, out_valid=1, in_ready=0.
  - Required: in_valid held high is not accepted until the cycle with out_ready=1, then the next pass starts with no idle cycle.
- Back-to-back: in_valid and out_ready held high, 4 coefficient sets.
  - Required: out_valid asserts every 9 cycles.
  - Required: all results match a bit-exact reference model, including random coefficients and random ROM contents, with ROM_W extremes −32768 and 32767.
- rst_n=0 for 1 cycle at SHIFT j=4.
  - Required: next cycle state IDLE, out_valid=0, out_data=0, addr1=addr2=0, in_ready=1.
  - Required: a following pass gives the correct result.
- Check addr1/addr2=0 in IDLE and DONE, and busy=1 only during the 8 SHIFT cycles.

Source files
------------

// File: rtl/idct_pkg.sv
// Shared state type and default widths for the distributed-arithmetic IDCT core.
package idct_pkg;
    localparam int IN_W  = 8;
    localparam int ROM_W = 16;
    localparam int OUT_W = 19;
    localparam int CNT_W = $clog2(IN_W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/idct_da_module_if.sv
// Coefficient-in / sample-out handshake bundle for the DA IDCT core.
interface idct_da_module_if #(
    parameter int IN_W  = idct_pkg::IN_W,
    parameter int OUT_W = idct_pkg::OUT_W
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  coef0;
    logic signed [IN_W-1:0]  coef1;
    logic signed [IN_W-1:0]  coef2;
    logic signed [IN_W-1:0]  coef3;
    logic signed [IN_W-1:0]  coef4;
    logic signed [IN_W-1:0]  coef5;
    logic signed [IN_W-1:0]  coef6;
    logic signed [IN_W-1:0]  coef7;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;

    modport master (
        output in_valid, coef0, coef1, coef2, coef3, coef4, coef5, coef6, coef7, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, coef0, coef1, coef2, coef3, coef4, coef5, coef6, coef7, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/coef_shift_reg.sv
// Parallel-load, right-shift register that presents one coefficient bit per cycle, LSB first.
module coef_shift_reg #(
    parameter int IN_W = idct_pkg::IN_W
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            load,
    input  logic            shift,
    input  logic [IN_W-1:0] din,
    output logic            lsb
);
    logic [IN_W-1:0] sr_q;
    logic [IN_W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = {1'b0, sr_q[IN_W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign lsb = sr_q[0];
endmodule

// File: rtl/idct_da_module.sv
// Distributed-arithmetic 8-point IDCT: bit-serial over the coefficients, one reconstructed sample per pass.
module idct_da_module
    import idct_pkg::*;
#(
    parameter int IN_W  = idct_pkg::IN_W,
    parameter int ROM_W = idct_pkg::ROM_W,
    parameter int OUT_W = idct_pkg::OUT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    idct_da_module_if.slave         io,
    output logic [2:0]              addr1,
    output logic [2:0]              addr2,
    input  logic signed [ROM_W-1:0] rom1_data,
    input  logic signed [ROM_W-1:0] rom2_data,
    output logic                    busy
);
    localparam int CW  = $clog2(IN_W);
    localparam int T_W = ROM_W + 2;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [OUT_W-1:0] acc_q, acc_d;

    logic [IN_W-1:0]         coef [8];
    logic [7:0]              b;
    logic                    load_en;
    logic                    shift_en;
    logic                    last_bit;
    logic signed [T_W-1:0]   rom1_x, rom2_x, p1, p2, t_sum;
    logic signed [OUT_W-1:0] t_ext, acc_half;

    assign coef[0] = io.coef0;
    assign coef[1] = io.coef1;
    assign coef[2] = io.coef2;
    assign coef[3] = io.coef3;
    assign coef[4] = io.coef4;
    assign coef[5] = io.coef5;
    assign coef[6] = io.coef6;
    assign coef[7] = io.coef7;

    for (genvar k = 0; k < 8; k++) begin : g_sr
        coef_shift_reg #(.IN_W(IN_W)) u_sr (
            .clk   (clk),
            .clr   (!rst_n),
            .load  (load_en),
            .shift (shift_en),
            .din   (coef[k]),
            .lsb   (b[k])
        );
    end

    // Offset-binary addressing: the first bit of each group picks the ROM half via its sign.
    assign addr1 = shift_en ? {b[0] ^ b[1], b[0] ^ b[2], b[0] ^ b[3]} : 3'b000;
    assign addr2 = shift_en ? {b[4] ^ b[5], b[4] ^ b[6], b[4] ^ b[7]} : 3'b000;

    assign rom1_x   = {{2{rom1_data[ROM_W-1]}}, rom1_data};
    assign rom2_x   = {{2{rom2_data[ROM_W-1]}}, rom2_data};
    assign p1       = b[0] ? -rom1_x : rom1_x;
    assign p2       = b[4] ? -rom2_x : rom2_x;
    assign t_sum    = p1 + p2;
    assign t_ext    = {{(OUT_W-T_W){t_sum[T_W-1]}}, t_sum};
    assign acc_half = acc_q >>> 1;

    assign last_bit     = (cnt_q == CW'(IN_W-1));
    assign shift_en     = (state_q == SHIFT);
    assign busy         = shift_en;
    assign io.in_ready  = (state_q == IDLE) || ((state_q == DONE) && io.out_ready);
    assign load_en      = io.in_valid && io.in_ready;
    assign io.out_valid = (state_q == DONE);
    assign io.out_data  = acc_q;

    // The sign-bit pass subtracts, which is what makes the serial sum two's complement.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (load_en) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            SHIFT: begin
                acc_d = last_bit ? (acc_half - t_ext) : (acc_half + t_ext);
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (load_en) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end
endmodule

// File: tb/tb_idct_da_module.sv
// Directed and table-driven bench for idct_da_module with a behavioural ROM pair.
module tb_idct_da_module;
    import idct_pkg::*;

    typedef struct {
        string                 name;
        logic [7:0][IN_W-1:0]  coef;
        logic [7:0][ROM_W-1:0] r1;
        logic [7:0][ROM_W-1:0] r2;
        logic                  chk_addr;
        logic [2:0]            a1;
        logic [2:0]            a2;
        logic                  chk_acc;
        int                    acc_seq [8];
        int                    exp_out;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [2:0]              addr1, addr2;
    logic signed [ROM_W-1:0] rom1_data, rom2_data;
    logic                    busy;
    logic [ROM_W-1:0]        rom1 [8];
    logic [ROM_W-1:0]        rom2 [8];
    int                      checks = 0;
    int                      errors = 0;
    vec_t                    vecs [4];
    vec_t                    bb [4];

    always #5 clk = ~clk;

    idct_da_module_if io ();

    assign rom1_data = $signed(rom1[addr1]);
    assign rom2_data = $signed(rom2[addr2]);

    idct_da_module dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io        (io),
        .addr1     (addr1),
        .addr2     (addr2),
        .rom1_data (rom1_data),
        .rom2_data (rom2_data),
        .busy      (busy)
    );

    task automatic checkOutput(input string name, input longint actual, input longint required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    function automatic vec_t blankVec(input string n);
        vec_t v;
        v.name     = n;
        v.coef     = '0;
        v.r1       = '0;
        v.r2       = '0;
        v.chk_addr = 1'b0;
        v.a1       = '0;
        v.a2       = '0;
        v.chk_acc  = 1'b0;
        v.exp_out  = 0;
        foreach (v.acc_seq[i]) v.acc_seq[i] = 0;
        return v;
    endfunction

    // Bit-serial reference: same arithmetic as the hardware description, in plain integers.
    function automatic int refModel(input vec_t v);
        logic signed [OUT_W-1:0] acc;
        logic [7:0]              bt;
        logic [2:0]              a1, a2;
        int                      p1, p2, t;
        acc = '0;
        for (int j = 0; j < IN_W; j++) begin
            for (int k = 0; k < 8; k++) bt[k] = v.coef[k][j];
            a1 = {bt[0] ^ bt[1], bt[0] ^ bt[2], bt[0] ^ bt[3]};
            a2 = {bt[4] ^ bt[5], bt[4] ^ bt[6], bt[4] ^ bt[7]};
            p1 = $signed(v.r1[a1]);
            p2 = $signed(v.r2[a2]);
            if (bt[0]) p1 = -p1;
            if (bt[4]) p2 = -p2;
            t = p1 + p2;
            if (j < IN_W - 1) acc = OUT_W'((int'(acc) >>> 1) + t);
            else              acc = OUT_W'((int'(acc) >>> 1) - t);
        end
        return int'(acc);
    endfunction

    task automatic driveCoefs(input logic [7:0][IN_W-1:0] c);
        io.coef0 = c[0];
        io.coef1 = c[1];
        io.coef2 = c[2];
        io.coef3 = c[3];
        io.coef4 = c[4];
        io.coef5 = c[5];
        io.coef6 = c[6];
        io.coef7 = c[7];
    endtask

    task automatic loadSet(input vec_t v);
        driveCoefs(v.coef);
        for (int k = 0; k < 8; k++) begin
            rom1[k] = v.r1[k];
            rom2[k] = v.r2[k];
        end
    endtask

    // Follows one pass from the cycle after the load handshake until out_valid or the cycle budget.
    task automatic waitResult(input vec_t v, output int data, output int cycles,
                              output int busy_cnt, output int addr_bad, output int acc_bad);
        logic [7:0][IN_W-1:0] junk;
        cycles   = 0;
        busy_cnt = 0;
        addr_bad = 0;
        acc_bad  = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (busy) begin
                busy_cnt++;
                if (v.chk_addr && (addr1 != v.a1 || addr2 != v.a2)) addr_bad++;
            end else if (addr1 != 3'd0 || addr2 != 3'd0) begin
                addr_bad++;
            end
            if (v.chk_acc && cycles >= 2 && cycles <= IN_W + 1 &&
                int'(dut.acc_q) != v.acc_seq[cycles-2]) acc_bad++;
            if (cycles == 1) begin
                io.in_valid = 1'b0;
                junk = {$urandom(), $urandom()};
                driveCoefs(junk);
            end
        end while (!io.out_valid && cycles < 40);
        data = int'(io.out_data);
    endtask

    task automatic applyStimulus(input vec_t v, input logic ready);
        int data, cycles, busy_cnt, addr_bad, acc_bad;
        @(negedge clk);
        loadSet(v);
        io.in_valid  = 1'b1;
        io.out_ready = ready;
        #1;
        checkOutput({v.name, "_in_ready"}, io.in_ready, 1);
        waitResult(v, data, cycles, busy_cnt, addr_bad, acc_bad);
        checkOutput({v.name, "_out_valid"}, io.out_valid, 1);
        checkOutput({v.name, "_latency"}, cycles, IN_W + 1);
        checkOutput({v.name, "_out_data"}, data, v.exp_out);
        checkOutput({v.name, "_busy_cycles"}, busy_cnt, IN_W);
        checkOutput({v.name, "_addr_errs"}, addr_bad, 0);
        if (v.chk_acc) checkOutput({v.name, "_acc_seq_errs"}, acc_bad, 0);
    endtask

    initial begin
        int data, cycles, busy_cnt, addr_bad, acc_bad;
        int done_cnt, cyc, last;

        vecs[0] = blankVec("zero_coefs");
        vecs[0].r1[0]    = 16'd100;
        vecs[0].r2[0]    = 16'd28;
        vecs[0].chk_addr = 1'b1;
        vecs[0].chk_acc  = 1'b1;
        vecs[0].acc_seq  = '{128, 192, 224, 240, 248, 252, 254, -1};
        vecs[0].exp_out  = -1;

        vecs[1] = blankVec("coef0_neg1");
        vecs[1].coef[0]  = 8'hFF;
        vecs[1].r1[7]    = 16'd64;
        vecs[1].r2[0]    = 16'd28;
        vecs[1].chk_addr = 1'b1;
        vecs[1].a1       = 3'd7;
        vecs[1].chk_acc  = 1'b1;
        vecs[1].acc_seq  = '{-36, -54, -63, -68, -70, -71, -72, 0};
        vecs[1].exp_out  = 0;

        vecs[2] = blankVec("coef1_one");
        vecs[2].coef[1] = 8'h01;
        vecs[2].r1[4]   = 16'd1000;
        vecs[2].exp_out = 7;

        vecs[3] = blankVec("coef4_min_rom_ext");
        vecs[3].coef[4] = 8'h80;
        vecs[3].r2[0]   = 16'h7FFF;
        vecs[3].r2[7]   = 16'h8000;
        vecs[3].exp_out = -257;

        rst_n        = 1'b0;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        driveCoefs('0);
        for (int k = 0; k < 8; k++) begin
            rom1[k] = '0;
            rom2[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", io.out_valid, 0);
        checkOutput("rst_out_data", io.out_data, 0);
        checkOutput("rst_in_ready", io.in_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_addr1", addr1, 0);
        checkOutput("rst_addr2", addr2, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) applyStimulus(vecs[i], 1'b1);

        // Stalled output: result must hold and a pending set must wait for out_ready.
        applyStimulus(vecs[2], 1'b0);
        loadSet(vecs[3]);
        io.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_out_valid", io.out_valid, 1);
            checkOutput("hold_in_ready", io.in_ready, 0);
            checkOutput("hold_out_data", io.out_data, vecs[2].exp_out);
        end
        io.out_ready = 1'b1;
        #1;
        checkOutput("hold_release_in_ready", io.in_ready, 1);
        waitResult(vecs[3], data, cycles, busy_cnt, addr_bad, acc_bad);
        checkOutput("hold_next_latency", cycles, IN_W + 1);
        checkOutput("hold_next_busy", busy_cnt, IN_W);
        checkOutput("hold_next_out_data", data, vecs[3].exp_out);

        // Reset pulse during bit 4 of a pass.
        @(negedge clk);
        loadSet(vecs[0]);
        io.in_valid = 1'b1;
        @(negedge clk);
        io.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("rst_mid_pre_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_in_ready", io.in_ready, 1);
        checkOutput("rst_mid_out_valid", io.out_valid, 0);
        checkOutput("rst_mid_out_data", io.out_data, 0);
        checkOutput("rst_mid_addr1", addr1, 0);
        checkOutput("rst_mid_addr2", addr2, 0);
        applyStimulus(vecs[1], 1'b1);

        // Back-to-back passes with random coefficients and ROMs, including ROM word extremes.
        for (int s = 0; s < 4; s++) begin
            bb[s] = blankVec("b2b");
            bb[s].coef = {$urandom(), $urandom()};
            for (int k = 0; k < 8; k++) begin
                bb[s].r1[k] = ROM_W'($urandom());
                bb[s].r2[k] = ROM_W'($urandom());
            end
        end
        for (int k = 0; k < 8; k++) begin
            bb[0].r1[k] = k[0] ? 16'h7FFF : 16'h8000;
            bb[0].r2[k] = 16'h8000;
        end
        bb[1].coef[0] = 8'h80;
        bb[1].coef[4] = 8'h7F;
        @(negedge clk);
        loadSet(bb[0]);
        io.in_valid  = 1'b1;
        io.out_ready = 1'b1;
        done_cnt = 0;
        cyc      = 0;
        last     = 0;
        while (done_cnt < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (io.out_valid) begin
                checkOutput("b2b_out_data", io.out_data, refModel(bb[done_cnt]));
                checkOutput("b2b_interval", cyc - last, IN_W + 1);
                last = cyc;
                done_cnt++;
                if (done_cnt < 4) loadSet(bb[done_cnt]);
                else io.in_valid = 1'b0;
            end
        end
        checkOutput("b2b_results", done_cnt, 4);

        @(negedge clk);
        checkOutput("end_out_valid", io.out_valid, 0);
        checkOutput("end_in_ready", io.in_ready, 1);
        checkOutput("end_busy", busy, 0);
        checkOutput("end_addr1", addr1, 0);
        checkOutput("end_addr2", addr2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
